// File: rtl/pixel_column_readout_ctrl_pkg.sv
// Shared encodings for the pixel column readout controller: FSM states,
// output word types and broadcast bit positions.
package commonDefinition;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_HEADER  = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_TRAILER = 3'd5
  } state_e;

  localparam logic [1:0] EVT_HEADER  = 2'b00;
  localparam logic [1:0] EVT_HIT     = 2'b01;
  localparam logic [1:0] EVT_TRAILER = 2'b10;

  localparam int BCST_LOAD     = 0;
  localparam int BCST_L1A      = 1;
  localparam int BCST_RESET    = 2;
  localparam int BCST_ADDR_LSB = 3;

  // Read counter width; wide enough for any drain timeout below 64 reads.
  localparam int CNT_W = 6;

endpackage

// File: rtl/pixel_column_readout_ctrl_l1a_addr_fifo.sv
// Small L1A address queue. A push into a full queue is dropped and flagged,
// unless a pop frees a slot in the same cycle. Flush empties it silently.
module l1a_addr_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign dout     = mem_q[rd_ptr_q];
  assign do_pop   = pop & ~empty & ~flush;
  assign do_push  = push & (~full | do_pop) & ~flush;
  assign overflow = push & full & ~do_pop & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_column_readout_ctrl.sv
// Column readout controller: queues L1A addresses, loads them into the
// switched-cell chain, then drains the column as header / hits / trailer.
module pixel_column_readout_ctrl
  import commonDefinition::*;
#(
  parameter int L1ADDRWIDTH = 7,
  parameter int BCSTWIDTH   = 27,
  parameter int SETTLE      = 16,
  parameter int MAXHITS     = 31
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   l1aIn,
  input  logic [L1ADDRWIDTH-1:0] l1aAddrIn,
  input  logic                   softReset,
  input  logic [45:0]            colData,
  input  logic [4:0]             colHits,
  output logic                   colRead,
  output logic [BCSTWIDTH-1:0]   bcstOut,
  output logic [45:0]            evtData,
  output logic [1:0]             evtType,
  output logic                   evtValid,
  input  logic                   evtReady,
  output logic                   busy,
  output logic [7:0]             ovfCount,
  output logic [2:0]             dbg_state
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e                 state_q, state_d;
  logic [L1ADDRWIDTH-1:0] addr_q, addr_d;
  logic [4:0]             exp_hits_q, exp_hits_d;
  logic [CNT_W-1:0]       read_cnt_q, read_cnt_d;
  logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic [45:0]            evt_data_q, evt_data_d;
  logic [1:0]             evt_type_q, evt_type_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [BCSTWIDTH-1:0]   bcst_q, bcst_d;
  logic [7:0]             ovf_q, ovf_d;

  logic                   fifo_pop;
  logic [L1ADDRWIDTH-1:0] fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_ovf;
  logic                   at_max;
  logic                   out_free;
  logic                   col_read;
  logic                   drain_done;

  l1a_addr_fifo #(
    .WIDTH (L1ADDRWIDTH),
    .DEPTH (4)
  ) u_l1a_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (softReset),
    .push     (l1aIn),
    .din      (l1aAddrIn),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  // Output handshake: a word transfers on a cycle with evtValid & evtReady;
  // while evtValid is high and evtReady low, evtData/evtType are held.
  assign at_max     = (read_cnt_q == CNT_W'(MAXHITS));
  assign out_free   = ~evt_valid_q | evtReady;
  assign col_read   = (state_q == ST_DRAIN) & ~softReset & (colHits != 5'd0)
                    & out_free & (read_cnt_q < CNT_W'(MAXHITS));
  assign drain_done = ((colHits == 5'd0) | at_max) & out_free;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    exp_hits_d   = exp_hits_q;
    read_cnt_d   = read_cnt_q;
    settle_cnt_d = settle_cnt_q;
    evt_data_d   = evt_data_q;
    evt_type_d   = evt_type_q;
    evt_valid_d  = evt_valid_q;
    bcst_d       = '0;
    fifo_pop     = 1'b0;
    ovf_d        = ovf_q;
    if (fifo_ovf && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;

    if (softReset) begin
      state_d            = ST_IDLE;
      evt_valid_d        = 1'b0;
      read_cnt_d         = '0;
      settle_cnt_d       = '0;
      bcst_d[BCST_RESET] = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop                                  = 1'b1;
            addr_d                                    = fifo_dout;
            state_d                                   = ST_LOAD;
            bcst_d[BCST_LOAD]                         = 1'b1;
            bcst_d[BCST_L1A]                          = 1'b1;
            bcst_d[BCST_ADDR_LSB +: L1ADDRWIDTH]      = fifo_dout;
          end
        end
        ST_LOAD: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SET_W'(SETTLE - 1)) begin
            state_d                          = ST_HEADER;
            exp_hits_d                       = colHits;
            evt_valid_d                      = 1'b1;
            evt_type_d                       = EVT_HEADER;
            evt_data_d                       = '0;
            evt_data_d[4:0]                  = colHits;
            evt_data_d[5 +: L1ADDRWIDTH]     = addr_q;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        ST_HEADER: begin
          if (evt_valid_q && evtReady) begin
            evt_valid_d = 1'b0;
            read_cnt_d  = '0;
            state_d     = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (col_read) begin
            evt_valid_d = 1'b1;
            evt_type_d  = EVT_HIT;
            evt_data_d  = colData;
            read_cnt_d  = read_cnt_q + 1'b1;
          end else if (drain_done) begin
            // Any pending hit word is accepted this cycle, so the trailer
            // can take the output register directly.
            state_d         = ST_TRAILER;
            evt_valid_d     = 1'b1;
            evt_type_d      = EVT_TRAILER;
            evt_data_d      = '0;
            evt_data_d[7]   = at_max;
            evt_data_d[6]   = (read_cnt_q != {1'b0, exp_hits_q});
            evt_data_d[5:0] = read_cnt_q;
          end else if (evt_valid_q && evtReady) begin
            evt_valid_d = 1'b0;
          end
        end
        ST_TRAILER: begin
          if (evt_valid_q && evtReady) begin
            evt_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      exp_hits_q   <= '0;
      read_cnt_q   <= '0;
      settle_cnt_q <= '0;
      evt_data_q   <= '0;
      evt_type_q   <= '0;
      evt_valid_q  <= 1'b0;
      bcst_q       <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      exp_hits_q   <= exp_hits_d;
      read_cnt_q   <= read_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      evt_data_q   <= evt_data_d;
      evt_type_q   <= evt_type_d;
      evt_valid_q  <= evt_valid_d;
      bcst_q       <= bcst_d;
      ovf_q        <= ovf_d;
    end
  end

  assign colRead   = col_read;
  assign bcstOut   = bcst_q;
  assign evtData   = evt_data_q;
  assign evtType   = evt_type_q;
  assign evtValid  = evt_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign ovfCount  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pixel_column_readout_ctrl.sv
// Directed bench for pixel_column_readout_ctrl with a behavioural column
// model and an expected-word queue.
module tb_pixel_column_readout_ctrl;
  import commonDefinition::*;

  localparam int AW = 7;
  localparam int BW = 27;

  logic          clk = 1'b0;
  logic          rstn;
  logic          l1aIn;
  logic [AW-1:0] l1aAddrIn;
  logic          softReset;
  logic [45:0]   colData;
  logic [4:0]    colHits;
  logic          colRead;
  logic [BW-1:0] bcstOut;
  logic [45:0]   evtData;
  logic [1:0]    evtType;
  logic          evtValid;
  logic          evtReady;
  logic          busy;
  logic [7:0]    ovfCount;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] exp_q[$];

  pixel_column_readout_ctrl #(
    .L1ADDRWIDTH (AW),
    .BCSTWIDTH   (BW),
    .SETTLE      (16),
    .MAXHITS     (31)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .l1aIn     (l1aIn),
    .l1aAddrIn (l1aAddrIn),
    .softReset (softReset),
    .colData   (colData),
    .colHits   (colHits),
    .colRead   (colRead),
    .bcstOut   (bcstOut),
    .evtData   (evtData),
    .evtType   (evtType),
    .evtValid  (evtValid),
    .evtReady  (evtReady),
    .busy      (busy),
    .ovfCount  (ovfCount),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // column model: hit count loaded from a per-address table on the load pulse
  int   hits_rem = 0;
  logic stuck = 1'b0;
  int   hits_by_addr[128];

  assign colHits = stuck ? 5'd1 : 5'(hits_rem);
  assign colData = {6'h2A, 35'h0, colHits};

  always @(posedge clk) begin
    if (bcstOut[2])                   hits_rem <= 0;
    else if (bcstOut[0])              hits_rem <= hits_by_addr[bcstOut[9:3]];
    else if (colRead && hits_rem > 0) hits_rem <= hits_rem - 1;
  end

  // monitor / scoreboard
  logic          mon_en = 1'b0;
  logic          stall_prev = 1'b0;
  logic [47:0]   held = '0;
  int            load_cycles = 0;
  int            read_cycles = 0;
  logic [BW-1:0] last_load = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bcstOut[0]) begin
        load_cycles++;
        last_load = bcstOut;
      end
      if (colRead) read_cycles++;
      if (stall_prev) begin
        check_eq("held_valid", evtValid, 1'b1);
        check_eq("held_word", {evtType, evtData}, held);
      end
      if (evtValid && !evtReady) check_eq("no_read_stalled", colRead, 1'b0);
      stall_prev = evtValid && !evtReady;
      held       = {evtType, evtData};
      if (evtValid && evtReady) begin
        check_eq("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_eq("word", {evtType, evtData}, exp_q.pop_front());
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  logic toggle = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle) evtReady = ~evtReady;
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic l1a(input logic [AW-1:0] a);
    l1aIn     = 1'b1;
    l1aAddrIn = a;
    cycles(1);
    l1aIn     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while ((busy || exp_q.size() != 0) && i < budget) begin
      cycles(1);
      i++;
    end
    check_eq({tag, "_done"}, i < budget, 1'b1);
  endtask

  function automatic logic [47:0] hdr(input logic [AW-1:0] a, input logic [4:0] h);
    return {2'b00, 34'h0, a, h};
  endfunction

  function automatic logic [47:0] hit(input logic [4:0] h);
    return {2'b01, 6'h2A, 35'h0, h};
  endfunction

  function automatic logic [47:0] trl(input logic [7:0] t);
    return {2'b10, 38'h0, t};
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) hits_by_addr[i] = 0;
    rstn      = 1'b0;
    l1aIn     = 1'b0;
    l1aAddrIn = '0;
    softReset = 1'b0;
    evtReady  = 1'b1;
    cycles(3);
    check_eq("rst_colRead", colRead, 1'b0);
    check_eq("rst_bcst", bcstOut, '0);
    check_eq("rst_valid", evtValid, 1'b0);
    check_eq("rst_data", {evtType, evtData}, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ovf", ovfCount, 8'd0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    rstn   = 1'b1;
    mon_en = 1'b1;

    // single event, 3 hits, L1A in the first cycle after release
    hits_by_addr[7'h15] = 3;
    exp_q.push_back(hdr(7'h15, 5'd3));
    exp_q.push_back(hit(5'd3));
    exp_q.push_back(hit(5'd2));
    exp_q.push_back(hit(5'd1));
    exp_q.push_back(trl(8'h03));
    load_cycles = 0;
    read_cycles = 0;
    l1a(7'h15);
    wait_done("t1", 200);
    check_eq("t1_load_cycles", load_cycles, 1);
    check_eq("t1_load_bcst", last_load, 27'h0AB);
    check_eq("t1_reads", read_cycles, 3);

    // zero hits
    exp_q.push_back(hdr(7'h2A, 5'd0));
    exp_q.push_back(trl(8'h00));
    read_cycles = 0;
    l1a(7'h2A);
    wait_done("t2", 200);
    check_eq("t2_reads", read_cycles, 0);

    // one event running, then six back-to-back L1As: four queued, two dropped
    for (int a = 1; a <= 5; a++) begin
      exp_q.push_back(hdr(AW'(a), 5'd0));
      exp_q.push_back(trl(8'h00));
    end
    load_cycles = 0;
    l1a(7'h01);
    cycles(3);
    for (int a = 2; a <= 7; a++) l1a(AW'(a));
    wait_done("t3", 1000);
    check_eq("t3_ovf", ovfCount, 8'd2);
    check_eq("t3_loads", load_cycles, 5);

    // backpressure: evtReady toggling during a 5-hit drain
    hits_by_addr[7'h33] = 5;
    exp_q.push_back(hdr(7'h33, 5'd5));
    for (int h = 5; h >= 1; h--) exp_q.push_back(hit(5'(h)));
    exp_q.push_back(trl(8'h05));
    read_cycles = 0;
    toggle = 1'b1;
    l1a(7'h33);
    wait_done("t4", 400);
    toggle   = 1'b0;
    evtReady = 1'b1;
    check_eq("t4_reads", read_cycles, 5);

    // stuck column: timeout after 31 reads, mismatch against expected 1
    stuck = 1'b1;
    exp_q.push_back(hdr(7'h0A, 5'd1));
    for (int i = 0; i < 31; i++) exp_q.push_back(hit(5'd1));
    exp_q.push_back(trl(8'hDF));
    read_cycles = 0;
    l1a(7'h0A);
    wait_done("t5", 400);
    stuck = 1'b0;
    check_eq("t5_reads", read_cycles, 31);

    // softReset mid-drain with a second address queued
    mon_en = 1'b0;
    hits_by_addr[7'h07] = 20;
    l1a(7'h07);
    cycles(2);
    l1a(7'h08);
    begin
      int i;
      i = 0;
      while (dbg_state != ST_DRAIN && i < 100) begin
        cycles(1);
        i++;
      end
      check_eq("t6_reach_drain", i < 100, 1'b1);
    end
    cycles(3);
    softReset = 1'b1;
    cycles(1);
    softReset = 1'b0;
    check_eq("t6_bcst_reset", bcstOut[2], 1'b1);
    check_eq("t6_bcst_load", bcstOut[0], 1'b0);
    check_eq("t6_valid", evtValid, 1'b0);
    check_eq("t6_state", dbg_state, ST_IDLE);
    check_eq("t6_colRead", colRead, 1'b0);
    cycles(5);
    check_eq("t6_fifo_empty_busy", busy, 1'b0);
    check_eq("t6_bcst_idle", bcstOut, '0);
    check_eq("t6_ovf_kept", ovfCount, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_column_readout_ctrl.md
PIXEL_COLUMN_READOUT_CTRL -- requirements
Module: pixel_column_readout_ctrl

Interface
REQ-001 Parameters SHALL be L1ADDRWIDTH (default 7), the L1A buffer address width, and BCSTWIDTH (default 27), the broadcast bus width.
REQ-002 Parameters SHALL also include SETTLE (default 16), the cycles from load to a stable chain hit count, and MAXHITS (default 31), the drain timeout in reads.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports clk (in, 1, 40 MHz) and rstn (in, 1, asynchronous active-low reset).
REQ-004 l1aIn (in, 1) SHALL be a one-cycle L1 accept request.
REQ-005 l1aAddrIn (in, L1ADDRWIDTH) SHALL be the L1A buffer address to read.
REQ-006 softReset (in, 1) SHALL be a chain reset request.
REQ-007 colData (in, 46) SHALL be the data word at the bottom of the switched-cell chain.
REQ-008 colHits (in, 5) SHALL be the pending hit count at the bottom of the chain.
REQ-009 colRead (out, 1) SHALL be the read strobe into the bottom cell.
REQ-010 bcstOut (out, BCSTWIDTH) SHALL be the broadcast into the bottom cell.
REQ-011 evtData (out, 46) and evtType (out, 2: 00 header, 01 hit, 10 trailer) SHALL form the output word.
REQ-012 evtValid (out, 1) and evtReady (in, 1) SHALL be the output handshake.
REQ-013 busy (out, 1) SHALL be high whenever the FSM is not in IDLE.
REQ-014 ovfCount (out, 8) SHALL count L1As dropped because the buffer was full, saturating at 255.

Function
REQ-015 bcstOut bit map SHALL be: [0] load, [1] L1A, [2] reset, [2+L1ADDRWIDTH:3] L1A address, and all remaining bits 0.
REQ-016 l1aIn SHALL push l1aAddrIn into a 4-entry FIFO; when the FIFO is full, the push SHALL be dropped and ovfCount incremented.
REQ-017 A simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-018 FSM states SHALL be IDLE, LOAD, SETTLE, HEADER, DRAIN, TRAILER.
REQ-019 IDLE SHALL go to LOAD when the FIFO is non-empty, popping one address.
REQ-020 LOAD SHALL last exactly one cycle, driving bcstOut with load=1, L1A=1 and address = the popped address; all other cycles SHALL drive load=L1A=0.
REQ-021 SETTLE SHALL count SETTLE cycles and then go to HEADER.
REQ-022 HEADER SHALL present evtType=00 with evtData = {zeros, address, colHits}, where colHits is sampled on HEADER entry as expHits, and SHALL go to DRAIN on the evtValid&evtReady handshake.
REQ-023 In DRAIN, colRead SHALL be combinational: colRead = (colHits!=0) & (~evtValid | evtReady) & (readCnt<MAXHITS).
REQ-024 On a colRead cycle, evtData<=colData and evtType<=01 SHALL be registered with evtValid=1 the next cycle (latency 1); back-to-back reads SHALL be allowed.
REQ-025 DRAIN SHALL go to TRAILER when colHits==0 with no pending evtValid, or when readCnt==MAXHITS.
REQ-026 TRAILER SHALL present evtType=10 with evtData = {zeros, timeout, mismatch, readCnt[5:0]}, where mismatch=(readCnt!=expHits), then SHALL return to IDLE on handshake.
REQ-027 evtValid SHALL hold with data stable until evtReady; no word SHALL be dropped or duplicated under backpressure.
REQ-028 Zero hits SHALL still produce a header and a trailer with readCnt=0.
REQ-029 softReset, in any state, SHALL drive bcst reset=1 for one cycle, flush the FIFO, deassert evtValid and colRead, return to IDLE, and leave ovfCount unchanged.

Reset
REQ-030 While rstn=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and the FIFO, readCnt and ovfCount SHALL be cleared.
REQ-031 rstn deassertion SHALL be synchronized by the user; the first L1A SHALL be accepted in the first cycle after release.

Structure
REQ-032 The evtType encodings, FSM state encodings and bcst bit indices SHALL live in a shared package (commonDefinition).
REQ-033 The L1A FIFO SHALL be one sub-module, l1a_addr_fifo (depth 4, width L1ADDRWIDTH).

Verification
REQ-034 One L1A with addr 0x15 and colHits=3, evtReady=1 -> load pulse 1 cycle, then header {0x15,3}, 3 hit words, trailer with readCnt=3 and mismatch=0.
REQ-035 One L1A with colHits=0 -> header with count 0, no colRead, trailer with readCnt=0.
REQ-036 6 L1As in consecutive cycles while busy -> 4 events processed in order, ovfCount=2.
REQ-037 evtReady toggling 1-0 during a 5-hit drain -> 5 hit words, each held stable while evtReady=0, and no colRead while the output is stalled.
REQ-038 colHits stuck at 1 -> exactly 31 reads, then trailer with timeout=1.
REQ-039 softReset mid-DRAIN -> bcst reset pulse, evtValid=0 next cycle, state IDLE, FIFO empty.
